// File: rtl/aes_round_sched.sv
// Round scheduler for an iterative AES core: arbitrates between two requesters,
// then sequences load, Nr round-key steps and a held completion for each job.
module aes_round_sched #(
  parameter int BASE_ROUNDS = 10,
  parameter int ROUND_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [1:0]         req0_mode,
  input  logic               req0_dec,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [1:0]         req1_mode,
  input  logic               req1_dec,
  output logic               req1_ready,
  output logic               core_load,
  output logic               core_en,
  output logic [ROUND_W-1:0] core_round,
  output logic [1:0]         core_mode,
  output logic               core_dec,
  output logic               core_last,
  output logic               done_valid,
  output logic               done_id,
  output logic               done_err,
  input  logic               done_ack,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_grant;
  logic [1:0]           r_mode;
  logic                 r_dec;
  logic                 r_id;
  logic                 r_err;
  logic [ROUND_W-1:0]   r_round;

  logic                 w_idle;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_xfer;
  logic                 w_xfer_id;
  logic [1:0]           w_xfer_mode;
  logic                 w_xfer_dec;
  logic                 w_xfer_bad;
  logic [ROUND_W-1:0]   w_nr;
  logic                 w_final;

  function automatic logic [ROUND_W-1:0] rounds_for(input logic [1:0] mode);
    return ROUND_W'(BASE_ROUNDS + 2 * int'(mode));
  endfunction

  // r_last_grant = 1 means requester 1 was served last, so requester 0 wins a tie.
  assign w_idle      = (r_state == S_IDLE);
  assign w_gnt0      = req0_valid & (~req1_valid | r_last_grant);
  assign w_gnt1      = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_xfer      = w_idle & (w_gnt0 | w_gnt1);
  assign w_xfer_id   = w_gnt1;
  assign w_xfer_mode = w_gnt1 ? req1_mode : req0_mode;
  assign w_xfer_dec  = w_gnt1 ? req1_dec  : req0_dec;
  assign w_xfer_bad  = (w_xfer_mode == MODE_ILLEGAL);

  assign w_nr    = rounds_for(r_mode);
  assign w_final = r_dec ? (r_round == '0) : (r_round == w_nr);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output and the next state get a default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    core_load   = 1'b0;
    core_en     = 1'b0;
    core_last   = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy       = 1'b0;
        req0_ready = w_gnt0;
        req1_ready = w_gnt1;
        if (w_xfer) begin
          w_state_nxt = w_xfer_bad ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        core_load   = 1'b1;
        w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        core_en   = 1'b1;
        core_last = w_final;
        if (w_final) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_valid = 1'b1;
        if (done_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Job fields are cleared on acknowledge so the core-facing outputs read 0 in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_mode       <= '0;
      r_dec        <= 1'b0;
      r_id         <= 1'b0;
      r_err        <= 1'b0;
      r_round      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_last_grant <= w_xfer_id;
            r_mode       <= w_xfer_mode;
            r_dec        <= w_xfer_dec;
            r_id         <= w_xfer_id;
            r_err        <= w_xfer_bad;
            r_round      <= (w_xfer_dec && !w_xfer_bad) ? rounds_for(w_xfer_mode) : '0;
          end
        end
        S_LOAD: begin
          r_round <= r_dec ? (r_round - ROUND_W'(1)) : (r_round + ROUND_W'(1));
        end
        S_ROUND: begin
          // Stepping stops at the final index, so the counter never wraps past 0 or Nr.
          if (w_final) begin
            r_round <= '0;
          end else begin
            r_round <= r_dec ? (r_round - ROUND_W'(1)) : (r_round + ROUND_W'(1));
          end
        end
        S_DONE: begin
          if (done_ack) begin
            r_mode  <= '0;
            r_dec   <= 1'b0;
            r_id    <= 1'b0;
            r_err   <= 1'b0;
            r_round <= '0;
          end
        end
        default: begin
          r_round <= '0;
        end
      endcase
    end
  end

  assign core_round = r_round;
  assign core_mode  = r_mode;
  assign core_dec   = r_dec;
  assign done_id    = done_valid & r_id;
  assign done_err   = done_valid & r_err;

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched: a transfer-relative timing model checked
// every cycle, plus directed jobs with hand-computed latencies and round sequences.
module tb_aes_round_sched;

  localparam int BASE    = 10;
  localparam int ROUND_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req0_valid, req1_valid;
  logic [1:0]         req0_mode, req1_mode;
  logic               req0_dec, req1_dec;
  logic               req0_ready, req1_ready;
  logic               core_load, core_en, core_dec, core_last;
  logic [ROUND_W-1:0] core_round;
  logic [1:0]         core_mode;
  logic               done_valid, done_id, done_err, done_ack, busy;

  aes_round_sched #(.BASE_ROUNDS(BASE), .ROUND_W(ROUND_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_mode  (req0_mode),
    .req0_dec   (req0_dec),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_mode  (req1_mode),
    .req1_dec   (req1_dec),
    .req1_ready (req1_ready),
    .core_load  (core_load),
    .core_en    (core_en),
    .core_round (core_round),
    .core_mode  (core_mode),
    .core_dec   (core_dec),
    .core_last  (core_last),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_err   (done_err),
    .done_ack   (done_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: job timing relative to its transfer cycle
  int         cyc  = 0;
  bit         m_busy = 1'b0;
  bit         m_lg   = 1'b1;
  int         m_t0   = 0;
  int         m_nr   = 0;
  bit         m_dec  = 1'b0;
  bit         m_id   = 1'b0;
  bit         m_err  = 1'b0;
  logic [1:0] m_mode = 2'd0;

  function automatic int winner(input bit v0, input bit v1, input bit lg);
    if (v0 && v1) return (lg == 1'b1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic bit in_done_phase(input int c, input int t0, input int nr, input bit err);
    if (err) return 1'b1;
    return (c - t0) >= (2 + nr);
  endfunction

  typedef struct {
    bit         r0, r1, load, en, last, done_v, busy_v, chk_round, dec, id, err;
    int         round;
    logic [1:0] mode;
  } exp_t;

  function automatic exp_t expect_now(input int c, input bit b, input int t0, input int nr,
                                      input bit dec, input bit err, input logic [1:0] mode,
                                      input bit id, input bit lg, input bit v0, input bit v1);
    exp_t e;
    int   k, j, w;
    e = '{default: 0};
    if (!b) begin
      w = winner(v0, v1, lg);
      e.r0 = (w == 0);
      e.r1 = (w == 1);
      e.chk_round = 1'b1;
      e.round = 0;
    end else begin
      e.busy_v = 1'b1;
      e.mode   = mode;
      e.dec    = dec;
      k = c - t0;
      if (err) begin
        e.done_v = 1'b1;
        e.id     = id;
        e.err    = 1'b1;
      end else if (k == 1) begin
        e.load = 1'b1;
        e.chk_round = 1'b1;
        e.round = dec ? nr : 0;
      end else if (k <= 1 + nr) begin
        j = k - 1;
        e.en = 1'b1;
        e.chk_round = 1'b1;
        e.round = dec ? (nr - j) : j;
        e.last  = (j == nr);
      end else begin
        e.done_v = 1'b1;
        e.id     = id;
      end
    end
    return e;
  endfunction

  int   m_win;
  exp_t e_now;
  assign m_win = winner(req0_valid, req1_valid, m_lg);
  assign e_now = expect_now(cyc, m_busy, m_t0, m_nr, m_dec, m_err, m_mode, m_id, m_lg,
                            req0_valid, req1_valid);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_lg   <= 1'b1;
    end else begin
      if (m_busy) begin
        if (in_done_phase(cyc, m_t0, m_nr, m_err) && done_ack) m_busy <= 1'b0;
      end else if (m_win >= 0) begin
        m_busy <= 1'b1;
        m_t0   <= cyc;
        m_id   <= (m_win == 1);
        m_lg   <= (m_win == 1);
        m_mode <= (m_win == 1) ? req1_mode : req0_mode;
        m_dec  <= (m_win == 1) ? req1_dec  : req0_dec;
        m_err  <= (((m_win == 1) ? req1_mode : req0_mode) == 2'd3);
        m_nr   <= BASE + 2 * int'((m_win == 1) ? req1_mode : req0_mode);
      end
      cyc <= cyc + 1;
    end
  end

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin
    check("cmp_ready0", req0_ready, e_now.r0);
    check("cmp_ready1", req1_ready, e_now.r1);
    check("cmp_load",   core_load,  e_now.load);
    check("cmp_en",     core_en,    e_now.en);
    check("cmp_last",   core_last,  e_now.last);
    check("cmp_done",   done_valid, e_now.done_v);
    check("cmp_busy",   busy,       e_now.busy_v);
    check("cmp_mode",   core_mode,  e_now.mode);
    check("cmp_dec",    core_dec,   e_now.dec);
    if (e_now.chk_round) check("cmp_round", core_round, e_now.round);
    if (e_now.done_v) begin
      check("cmp_done_id",  done_id,  e_now.id);
      check("cmp_done_err", done_err, e_now.err);
    end
  end

  // ---------------- event log used by the directed checks
  int t_xfer = 0, load_cyc = 0, load_round = 0, last_round = 0, done_rise_cyc = 0;
  int n_load = 0, n_en = 0, n_last = 0, n_done_rise = 0, n_ready_busy = 0;
  bit prev_done = 1'b0;
  int q_grant[$];
  int q_rounds[$];

  always @(negedge clk) begin
    if (req0_valid && req0_ready) begin t_xfer <= cyc; q_grant.push_back(0); end
    if (req1_valid && req1_ready) begin t_xfer <= cyc; q_grant.push_back(1); end
    if (core_load) begin n_load <= n_load + 1; load_cyc <= cyc; load_round <= int'(core_round); end
    if (core_en) begin
      n_en <= n_en + 1;
      q_rounds.push_back(int'(core_round));
      if (core_last) begin n_last <= n_last + 1; last_round <= int'(core_round); end
    end
    if (done_valid && !prev_done) begin n_done_rise <= n_done_rise + 1; done_rise_cyc <= cyc; end
    if ((req0_ready || req1_ready) && busy) n_ready_busy <= n_ready_busy + 1;
    prev_done <= done_valid;
  end

  int b_load, b_en, b_last, b_done, b_grant, b_rounds;

  task automatic snap();
    b_load = n_load; b_en = n_en; b_last = n_last; b_done = n_done_rise;
    b_grant = q_grant.size(); b_rounds = q_rounds.size();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_valid) begin seen = 1'b1; break; end
    end
    check({name, "_done_seen"}, seen, 1);
  endtask

  task automatic ack(input string name);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    check({name, "_idle_after_ack"}, busy, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; done_ack = 1'b0;
    req0_valid = 1'b0; req0_mode = 2'd0; req0_dec = 1'b0;
    req1_valid = 1'b0; req1_mode = 2'd0; req1_dec = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done_valid, 0);
    check("rst_round", core_round, 0);
    check("rst_load_en", {core_load, core_en}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Job 1: req0 encrypt, 128-bit key
    snap();
    req0_valid = 1'b1; req0_mode = 2'd0; req0_dec = 1'b0;
    #1 check("t1_ready0_same_cycle", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    wait_done(40, "t1");
    check("t1_load_lat", load_cyc - t_xfer, 1);
    check("t1_load_round", load_round, 0);
    check("t1_nrounds", q_rounds.size() - b_rounds, 10);
    if (q_rounds.size() >= b_rounds + 10)
      for (int i = 0; i < 10; i++) check("t1_round_seq", q_rounds[b_rounds + i], i + 1);
    check("t1_last_round", last_round, 10);
    check("t1_nlast", n_last - b_last, 1);
    check("t1_done_lat", done_rise_cyc - t_xfer, 12);
    check("t1_id", done_id, 0);
    check("t1_err", done_err, 0);
    ack("t1");

    // Job 2: req1 decrypt, 256-bit key
    snap();
    req1_valid = 1'b1; req1_mode = 2'd2; req1_dec = 1'b1;
    tick();
    req1_valid = 1'b0;
    wait_done(40, "t2");
    check("t2_load_round", load_round, 14);
    check("t2_nrounds", q_rounds.size() - b_rounds, 14);
    if (q_rounds.size() >= b_rounds + 14)
      for (int i = 0; i < 14; i++) check("t2_round_seq", q_rounds[b_rounds + i], 13 - i);
    check("t2_last_round", last_round, 0);
    check("t2_done_lat", done_rise_cyc - t_xfer, 16);
    check("t2_id", done_id, 1);
    ack("t2");

    // Contention: both valid for three jobs
    snap();
    req0_valid = 1'b1; req0_mode = 2'd0; req0_dec = 1'b0;
    req1_valid = 1'b1; req1_mode = 2'd0; req1_dec = 1'b0;
    for (int j = 0; j < 3; j++) begin
      wait_done(40, "t3");
      if (j == 2) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      ack("t3");
    end
    check("t3_ngrants", q_grant.size() - b_grant, 3);
    if (q_grant.size() >= b_grant + 3) begin
      check("t3_grant0", q_grant[b_grant],     0);
      check("t3_grant1", q_grant[b_grant + 1], 1);
      check("t3_grant2", q_grant[b_grant + 2], 0);
    end
    check("t3_ready_while_busy", n_ready_busy, 0);

    // Illegal mode
    snap();
    req0_valid = 1'b1; req0_mode = 2'd3; req0_dec = 1'b0;
    tick();
    req0_valid = 1'b0;
    wait_done(10, "t4");
    check("t4_done_lat", done_rise_cyc - t_xfer, 1);
    check("t4_err", done_err, 1);
    check("t4_id", done_id, 0);
    check("t4_no_load", n_load - b_load, 0);
    check("t4_no_en", n_en - b_en, 0);
    ack("t4");

    // Held completion, stray ack, transient request, pending grant after ack
    snap();
    req1_valid = 1'b1; req1_mode = 2'd0; req1_dec = 1'b0;
    tick();
    req1_valid = 1'b0; req0_valid = 1'b1; req0_mode = 2'd0;
    tick();
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0; req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    wait_done(40, "t5");
    check("t5_done_lat", done_rise_cyc - t_xfer, 12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("t5_hold_valid", done_valid, 1);
      check("t5_hold_id", done_id, 1);
    end
    ack("t5");
    check("t5_pending_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    check("t5_ngrants", q_grant.size() - b_grant, 2);
    if (q_grant.size() >= b_grant + 2) check("t5_grant_pending", q_grant[b_grant + 1], 0);
    wait_done(40, "t5b");
    ack("t5b");

    // Reset during round 5 of a 192-bit job
    snap();
    req0_valid = 1'b1; req0_mode = 2'd1; req0_dec = 1'b0;
    tick();
    req0_valid = 1'b0;
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        #1;
        if (core_en && core_round == 5) begin hit = 1'b1; break; end
      end
      check("t6_reached_round5", hit, 1);
    end
    rst_n = 1'b0;
    #1;
    check("t6_rst_en", core_en, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_round", core_round, 0);
    check("t6_rst_mode", core_mode, 0);
    check("t6_rst_done", done_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("t6_no_done", n_done_rise - b_done, 0);
    snap();
    req0_valid = 1'b1; req0_mode = 2'd0;
    req1_valid = 1'b1; req1_mode = 2'd0;
    #1;
    check("t6_ready0", req0_ready, 1);
    check("t6_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_done(40, "t6");
    check("t6_id", done_id, 0);
    ack("t6");

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 Parameter BASE_ROUNDS, default 10: round count for mode 0; Nr = BASE_ROUNDS + 2*mode.
REQ-002 Parameter ROUND_W, default 4: width of core_round; SHALL hold BASE_ROUNDS+4.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  in  1  requester job request.
REQ-006 req0_mode / req1_mode  in  2  key size: 0=128, 1=192, 2=256, 3=illegal.
REQ-007 req0_dec / req1_dec  in  1  0=encrypt, 1=decrypt.
REQ-008 req0_ready / req1_ready  out  1  grant; transfer = valid & ready.
REQ-009 core_load  out  1  one-cycle pulse: core latches block, applies initial AddRoundKey.
REQ-010 core_en  out  1  core executes round core_round this cycle.
REQ-011 core_round  out  ROUND_W  round key index for the current load or round.
REQ-012 core_mode / core_dec  out  2 / 1  latched job mode and direction, stable from load until done.
REQ-013 core_last  out  1  marks the final round, coincident with core_en.
REQ-014 done_valid  out  1  job complete, held until acknowledged.
REQ-015 done_id / done_err  out  1 / 1  winning requester; illegal-mode flag.
REQ-016 done_ack  in  1  consumer acknowledge of done_valid.
REQ-017 busy  out  1  high whenever state != IDLE.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, ROUND, DONE.
REQ-019 IDLE: readyX = 1 only for the arbitration winner; readyX is combinational from valids and last_grant, and is 0 in every other state.
REQ-020 Arbitration is round-robin: a single valid wins; if both are valid, the requester != last_grant wins; last_grant updates on each transfer.
REQ-021 On transfer, latch mode, dec, id; mode 1..2 or 0 -> LOAD; mode 3 -> DONE with done_err=1, no core_load or core_en.
REQ-022 LOAD (1 cycle): core_load=1; core_round = 0 when encrypting, Nr when decrypting; next state ROUND.
REQ-023 ROUND: core_en=1 for exactly Nr cycles; encrypt: core_round 1,2..Nr; decrypt: Nr-1..0.
REQ-024 core_last=1 only in the cycle with core_round=Nr (encrypt) or 0 (decrypt); the next state is DONE.
REQ-025 DONE: done_valid=1, with done_id and done_err stable; done_ack while done_valid -> IDLE next cycle; the next grant comes no earlier than the IDLE cycle.
REQ-026 Latency: transfer in cycle T -> core_load in T+1 -> rounds in T+2..T+1+Nr -> done_valid from T+2+Nr. For mode 0 that is 12 cycles, mode 1 14, mode 2 16.
REQ-027 Illegal mode: done_valid rises in T+1.
REQ-028 done_ack while not in DONE SHALL be ignored.
REQ-029 A requester dropping valid before its grant SHALL leave no state change.
REQ-030 Requester inputs SHALL be ignored outside IDLE.
REQ-031 The round counter SHALL never wrap: it stays within 0..Nr.
REQ-032 core_round, core_mode, core_dec SHALL read 0 in IDLE.

Reset
REQ-033 On rst_n=0, asynchronously: state=IDLE, last_grant=1, all latched fields 0, all outputs 0 except the combinational readyX.
REQ-034 Reset mid-ROUND SHALL abort the job with no done_valid; after release, req0 wins the first contention.

Verification
REQ-035 Reset, then req0 encrypt mode 0 -> ready0 in the same cycle; core_load at T+1 with round 0; rounds 1..10 with core_last on 10; done_valid at T+12 with id=0, err=0.
REQ-036 req1 decrypt mode 2 -> core_load with round 14; rounds 13..0 with core_last on 0; done_valid at T+16.
REQ-037 Both valid, continuously, 3 jobs -> grants in the order 0, 1, 0; no grant while busy.
REQ-038 req0 mode 3 -> done_valid at T+1 with err=1; core_load and core_en never asserted.
REQ-039 Hold done_ack=0 for 5 cycles -> done_valid and done_id held; ack -> IDLE next cycle, pending request granted then.
REQ-040 rst_n low during round 5 of a mode 1 job -> outputs 0 immediately; no done_valid; next contention won by req0.
